// File: rtl/jtopl_op_csr.sv
// Operator register ring: SLOTS words recirculate through a shift register, with one
// buffered masked byte write and one buffered byte read serviced as the target slot passes.
module jtopl_op_csr #(
   parameter  int unsigned SLOTS = 18,
   parameter  int unsigned BYTES = 4,
   parameter  int unsigned SW    = 5,
   parameter  int unsigned BW    = 2,
   localparam int unsigned W     = 8 * BYTES
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen,
   output logic [W-1:0]  shift_out,
   output logic [SW-1:0] slot_cnt,
   output logic          slot_zero,
   input  logic          wr_req,
   input  logic [SW-1:0] wr_slot,
   input  logic [BW-1:0] wr_byte,
   input  logic [7:0]    wr_mask,
   input  logic [7:0]    wr_data,
   output logic          wr_busy,
   output logic          wr_err,
   input  logic          rd_req,
   input  logic [SW-1:0] rd_slot,
   input  logic [BW-1:0] rd_byte,
   output logic          rd_busy,
   output logic          rd_valid,
   output logic [7:0]    rd_data
);

   localparam logic [SW:0]   SLOTS_LIM = (SW+1)'(SLOTS);
   localparam logic [BW:0]   BYTES_LIM = (BW+1)'(BYTES);
   localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

   logic [W-1:0]  stage [SLOTS];
   logic [W-1:0]  next_word;
   logic [7:0]    rd_sel;
   logic [SW-1:0] pw_slot;
   logic [BW-1:0] pw_byte;
   logic [7:0]    pw_mask;
   logic [7:0]    pw_data;
   logic [SW-1:0] pr_slot;
   logic [BW-1:0] pr_byte;
   logic          wr_hit;
   logic          rd_hit;
   logic          wr_ok;
   logic          rd_ok;

   assign shift_out = stage[SLOTS-1];
   assign wr_hit    = wr_busy && (slot_cnt == pw_slot);
   assign rd_hit    = rd_busy && (slot_cnt == pr_slot);
   assign wr_ok     = ({1'b0, wr_slot} < SLOTS_LIM) && ({1'b0, wr_byte} < BYTES_LIM);
   assign rd_ok     = ({1'b0, rd_slot} < SLOTS_LIM) && ({1'b0, rd_byte} < BYTES_LIM);

   // Merge the pending masked byte into the word re-entering the ring
   always_comb begin
      next_word = shift_out;
      for (int b = 0; b < int'(BYTES); b++) begin
         if (wr_hit && (pw_byte == BW'(b)))
            next_word[8*b +: 8] = (shift_out[8*b +: 8] & ~pw_mask) | (pw_data & pw_mask);
      end
   end

   // Readback byte taken from the pre-write word at the last stage
   always_comb begin
      rd_sel = '0;
      for (int b = 0; b < int'(BYTES); b++) begin
         if (pr_byte == BW'(b))
            rd_sel = shift_out[8*b +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(SLOTS); k++)
            stage[k] <= '0;
      end else if (cen) begin
         stage[0] <= next_word;
         for (int k = 1; k < int'(SLOTS); k++)
            stage[k] <= stage[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt  <= '0;
         slot_zero <= 1'b1;
      end else if (cen) begin
         slot_cnt  <= (slot_cnt == LAST_SLOT) ? '0 : slot_cnt + SW'(1);
         slot_zero <= (slot_cnt == LAST_SLOT);
      end
   end

   // Write request buffer; requests while busy are ignored
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_busy <= 1'b0;
         wr_err  <= 1'b0;
         pw_slot <= '0;
         pw_byte <= '0;
         pw_mask <= '0;
         pw_data <= '0;
      end else begin
         wr_err <= 1'b0;
         if (wr_busy) begin
            if (cen && wr_hit)
               wr_busy <= 1'b0;
         end else if (wr_req) begin
            if (wr_ok) begin
               wr_busy <= 1'b1;
               pw_slot <= wr_slot;
               pw_byte <= wr_byte;
               pw_mask <= wr_mask;
               pw_data <= wr_data;
            end else begin
               wr_err <= 1'b1;
            end
         end
      end
   end

   // Read request buffer; out-of-range reads are dropped silently
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_busy  <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         pr_slot  <= '0;
         pr_byte  <= '0;
      end else begin
         rd_valid <= 1'b0;
         if (rd_busy) begin
            if (cen && rd_hit) begin
               rd_busy  <= 1'b0;
               rd_valid <= 1'b1;
               rd_data  <= rd_sel;
            end
         end else if (rd_req && rd_ok) begin
            rd_busy <= 1'b1;
            pr_slot <= rd_slot;
            pr_byte <= rd_byte;
         end
      end
   end

endmodule

// File: tb/tb_jtopl_op_csr.sv
// Scoreboard bench for jtopl_op_csr: a slot/byte memory model predicts ring contents,
// readback bytes and error pulses; a negedge monitor pops and compares DUT outputs.
module tb_jtopl_op_csr;

   localparam int SLOTS = 18;
   localparam int BYTES = 4;
   localparam int SW    = 5;
   localparam int BW    = 2;

   logic          clk;
   logic          rst_n;
   logic          cen;
   logic [31:0]   shift_out;
   logic [SW-1:0] slot_cnt;
   logic          slot_zero;
   logic          wr_req;
   logic [SW-1:0] wr_slot;
   logic [BW-1:0] wr_byte;
   logic [7:0]    wr_mask;
   logic [7:0]    wr_data;
   logic          wr_busy;
   logic          wr_err;
   logic          rd_req;
   logic [SW-1:0] rd_slot;
   logic [BW-1:0] rd_byte;
   logic          rd_busy;
   logic          rd_valid;
   logic [7:0]    rd_data;

   jtopl_op_csr #(.SLOTS(SLOTS), .BYTES(BYTES), .SW(SW), .BW(BW)) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen),
      .shift_out(shift_out), .slot_cnt(slot_cnt), .slot_zero(slot_zero),
      .wr_req(wr_req), .wr_slot(wr_slot), .wr_byte(wr_byte),
      .wr_mask(wr_mask), .wr_data(wr_data), .wr_busy(wr_busy), .wr_err(wr_err),
      .rd_req(rd_req), .rd_slot(rd_slot), .rd_byte(rd_byte),
      .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_data(rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          slot;
      logic [31:0] word;
   } sh_t;

   int          n_checks = 0;
   int          n_pass   = 0;
   sh_t         exp_sh[$];
   logic [7:0]  exp_rd[$];
   int          err_pend;

   // Reference model: register file indexed by slot and byte, plus the ring position
   logic [7:0]  m_mem [SLOTS][BYTES];
   int          m_cnt;
   bit          m_wbusy, m_rbusy;
   int          m_ws, m_wb, m_rs, m_rb;
   logic [7:0]  m_wm, m_wd;
   logic [SW-1:0] prev_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] mword(input int s);
      logic [31:0] w;
      w = '0;
      for (int b = 0; b < BYTES; b++) w[8*b +: 8] = m_mem[s][b];
      return w;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < SLOTS; s++)
         for (int b = 0; b < BYTES; b++) m_mem[s][b] = 8'h00;
      m_cnt = 0;
      m_wbusy = 0;
      m_rbusy = 0;
      exp_sh.delete();
      exp_rd.delete();
      err_pend = 0;
   endtask

   // Predict the effect of the coming clock edge from the inputs now driven
   task automatic model_edge();
      bit wb0, rb0;
      wb0 = m_wbusy;
      rb0 = m_rbusy;
      if (cen) begin
         if (rb0 && m_cnt == m_rs) begin
            exp_rd.push_back(m_mem[m_rs][m_rb]);
            m_rbusy = 0;
         end
         if (wb0 && m_cnt == m_ws) begin
            m_mem[m_ws][m_wb] = (m_mem[m_ws][m_wb] & ~m_wm) | (m_wd & m_wm);
            m_wbusy = 0;
         end
         m_cnt = (m_cnt + 1) % SLOTS;
         exp_sh.push_back('{slot: m_cnt, word: mword(m_cnt)});
      end
      if (wr_req && !wb0) begin
         if (int'(wr_slot) < SLOTS && int'(wr_byte) < BYTES) begin
            m_wbusy = 1;
            m_ws = int'(wr_slot); m_wb = int'(wr_byte);
            m_wm = wr_mask; m_wd = wr_data;
         end else begin
            err_pend++;
         end
      end
      if (rd_req && !rb0 && int'(rd_slot) < SLOTS && int'(rd_byte) < BYTES) begin
         m_rbusy = 1;
         m_rs = int'(rd_slot); m_rb = int'(rd_byte);
      end
   endtask

   task automatic cyc(input bit c, input bit wq, input int ws, input int wb, input int wm,
                      input int wd, input bit rq, input int rs, input int rb);
      cen = c; wr_req = wq; wr_slot = 5'(ws); wr_byte = 2'(wb);
      wr_mask = 8'(wm); wr_data = 8'(wd);
      rd_req = rq; rd_slot = 5'(rs); rd_byte = 2'(rb);
      model_edge();
      @(posedge clk); #1;
      chk("wr_busy", {31'd0, wr_busy}, {31'd0, m_wbusy});
      chk("rd_busy", {31'd0, rd_busy}, {31'd0, m_rbusy});
      if (!c) begin
         chk("frozen_slot_cnt", 32'(slot_cnt), 32'(m_cnt));
         chk("frozen_shift_out", shift_out, mword(m_cnt));
      end
   endtask

   task automatic idle(input int n, input bit c);
      for (int i = 0; i < n; i++) cyc(c, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wr1(input int s, input int b, input int m, input int d);
      cyc(1, 1, s, b, m, d, 0, 0, 0);
   endtask

   task automatic rd1(input int s, input int b);
      cyc(1, 0, 0, 0, 0, 0, 1, s, b);
   endtask

   // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge
   task automatic do_reset();
      rst_n = 1'b0;
      cen = 0; wr_req = 0; rd_req = 0;
      model_reset();
      #1;
      chk("rst_shift_out", shift_out, 32'h0);
      chk("rst_slot_cnt", 32'(slot_cnt), 32'h0);
      chk("rst_slot_zero", {31'd0, slot_zero}, 32'h1);
      chk("rst_wr_busy", {31'd0, wr_busy}, 32'h0);
      chk("rst_rd_busy", {31'd0, rd_busy}, 32'h0);
      chk("rst_wr_err", {31'd0, wr_err}, 32'h0);
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'h0);
      chk("rst_rd_data", 32'(rd_data), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Monitor: pop an expectation whenever the ring advances, a read returns or an error pulses
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_cnt = '0;
      end else begin
         if (slot_cnt != prev_cnt) begin
            if (exp_sh.size() == 0) begin
               n_checks++;
               $display("FAIL shift_advance: slot_cnt moved to %0d with no cen edge expected", slot_cnt);
            end else begin
               sh_t e;
               e = exp_sh.pop_front();
               chk("slot_cnt", 32'(slot_cnt), 32'(e.slot));
               chk("shift_out", shift_out, e.word);
               chk("slot_zero", {31'd0, slot_zero}, (e.slot == 0) ? 32'h1 : 32'h0);
            end
            prev_cnt = slot_cnt;
         end
         if (rd_valid) begin
            if (exp_rd.size() == 0) begin
               n_checks++;
               $display("FAIL rd_valid: pulse with data 0x%0h but no read expected", rd_data);
            end else begin
               chk("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
            end
         end
         if (wr_err) begin
            n_checks++;
            if (err_pend > 0) begin
               err_pend--;
               n_pass++;
            end else begin
               $display("FAIL wr_err: got pulse 1 expected 0 at %0t", $time);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      cen = 0; wr_req = 0; rd_req = 0;
      wr_slot = '0; wr_byte = '0; wr_mask = '0; wr_data = '0;
      rd_slot = '0; rd_byte = '0;
      model_reset();
      @(posedge clk); #1;
      do_reset();

      // Free-running ring: two full revolutions of zeros
      idle(2 * SLOTS, 1);

      // Full-byte write into the top byte of slot 5
      wr1(5, 3, 8'hFF, 8'hA5);
      idle(SLOTS + 2, 1);

      // Masked write over a preloaded byte
      wr1(2, 1, 8'hFF, 8'hF0);
      idle(SLOTS + 1, 1);
      wr1(2, 1, 8'h0F, 8'h3C);
      idle(SLOTS + 1, 1);
      rd1(2, 1);
      idle(SLOTS + 1, 1);

      // Simultaneous read and write of the same byte: old value returned, write lands
      wr1(7, 0, 8'hFF, 8'h11);
      idle(SLOTS + 1, 1);
      cyc(1, 1, 7, 0, 8'hFF, 8'h22, 1, 7, 0);
      idle(SLOTS + 1, 1);
      rd1(7, 0);
      idle(SLOTS + 1, 1);

      // Out-of-range slot, highest byte, and a second request while busy
      wr1(18, 0, 8'hFF, 8'h55);
      wr1(31, 2, 8'hFF, 8'h66);
      wr1(9, 3, 8'hFF, 8'hC3);
      wr1(9, 3, 8'hFF, 8'h00);
      wr1(4, 0, 8'hFF, 8'h99);
      idle(SLOTS + 1, 1);

      // Mask 0x00 write: no data change, busy still clears
      wr1(9, 3, 8'h00, 8'hFF);
      idle(SLOTS + 1, 1);

      // Reset while a write is pending
      wr1((m_cnt + 10) % SLOTS, 2, 8'hFF, 8'h77);
      idle(3, 1);
      do_reset();
      idle(2 * SLOTS, 1);

      // Pending write across a 10-cycle cen stall
      wr1((m_cnt + 5) % SLOTS, 1, 8'hFF, 8'h5A);
      idle(10, 0);
      idle(SLOTS + 2, 1);

      // Randomised traffic including out-of-range addresses and cen gaps
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, int'($urandom_range(0, 21)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             $urandom_range(0, 2) == 0, int'($urandom_range(0, 21)), int'($urandom_range(0, 3)));
      end

      // Drain outstanding requests, then confirm every expectation was consumed
      idle(SLOTS + 2, 1);
      @(negedge clk); #1;
      chk("shift_queue_drained", 32'(exp_sh.size()), 32'h0);
      chk("read_queue_drained", 32'(exp_rd.size()), 32'h0);
      chk("err_pulses_seen", 32'(err_pend), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
